// File: rtl/seq_divider_32.sv
// seq_divider_32: multi-cycle unsigned restoring divider built around a shared adder/subtractor
module addsub_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  logic [WIDTH:0] w_full;
  // two's-complement subtract when m=1: a + ~b + 1, carry-out set means no borrow
  always_comb w_full = {1'b0, a} + {1'b0, b ^ {WIDTH{m}}} + {{WIDTH{1'b0}}, m};
  assign {c_out, sum} = w_full;
endmodule

module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic [WIDTH-1:0] w_r_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_cout;
  logic             w_acc;
  logic [WIDTH-1:0] w_r_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic             w_last;
  // shift the next dividend bit into the partial remainder
  assign w_r_sh = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  addsub_32 #(.WIDTH(WIDTH)) u_sub (
    .a    (w_r_sh),
    .b    (r_d),
    .m    (1'b1),
    .sum  (w_diff),
    .c_out(w_cout)
  );
  // a bit shifted out of the top means the true remainder exceeds any divisor
  assign w_acc  = r_r[WIDTH-1] | w_cout;
  assign w_r_nx = w_acc ? w_diff : w_r_sh;
  assign w_q_nx = {r_q[WIDTH-2:0], w_acc};
  assign w_last = r_cnt == CW'(1);
  // control FSM, datapath registers and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_d     <= divisor;
            r_q     <= dividend;
            r_r     <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH);
            r_state <= divisor == '0 ? FIN : RUN;
          end
        end
        RUN: begin
          r_r   <= w_r_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_quot  <= w_q_nx;
            r_rem   <= w_r_nx;
          end
        end
        FIN: begin
          // arriving from RUN, done is already up; arriving straight from IDLE means divide by zero
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_quot <= '1;
            r_rem  <= r_q;
            r_dbz  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider_32.sv
// tb_seq_divider_32: randomized and directed checks of seq_divider_32 against plain-arithmetic division
module tb_seq_divider_32;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  seq_divider_32 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // one complete division; pulse_at>0 re-pulses start (with junk operands) so it reaches edge T<pulse_at>
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int pulse_at, input string name);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          elat;
    int          n;
    bit          seen;
    bit          busy_bad;
    eq   = b == 0 ? 32'hFFFF_FFFF : a / b;
    er   = b == 0 ? a : a % b;
    edz  = b == 0;
    elat = b == 0 ? 1 : 32;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== prev_q || remainder !== prev_r) begin
      failures++;
      $display("FAIL %s idle_hold: done=%b busy=%b q=%h r=%h, required done=0 busy=0 q=%h r=%h",
               name, done, busy, quotient, remainder, prev_q, prev_r);
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    seen     = 0;
    busy_bad = 0;
    for (n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        checks++;
        if (n - 1 != elat) begin
          failures++;
          $display("FAIL %s latency: done at T%0d, required T%0d", name, n - 1, elat);
        end
        checks++;
        if (quotient !== eq || remainder !== er) begin
          failures++;
          $display("FAIL %s result: q=%h r=%h, required q=%h r=%h", name, quotient, remainder, eq, er);
        end
        checks++;
        if (div_by_zero !== edz || busy !== 1'b0) begin
          failures++;
          $display("FAIL %s flags: dbz=%b busy=%b, required dbz=%b busy=0", name, div_by_zero, busy, edz);
        end
      end else begin
        if (busy !== 1'b1 || quotient !== prev_q || remainder !== prev_r) busy_bad = 1;
      end
      start = (n == pulse_at) ? 1'b1 : 1'b0;
      if (n == pulse_at) begin
        dividend = $urandom;
        divisor  = $urandom | 32'd1;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout: done=0 after 40 cycles, required done pulse", name);
    end
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL %s in_flight: busy dropped or outputs changed before done, required busy=1 and held results", name);
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    checks++;
    if (busy !== 0 || done !== 0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b q=%h r=%h dbz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 0, "basic_100_7");
    do_div(32'hFFFF_FFFF, 32'h8000_0001, 0, "msb_shift");
    do_div(32'hFFFF_FFFF, 32'h0000_0001, 0, "div_by_one");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0, "big_divisor");
    do_div(32'd0, 32'd5, 0, "zero_dividend");
    do_div(32'h1234, 32'd0, 0, "div_zero");
    do_div(32'd9, 32'd3, 0, "after_div_zero");
  endtask

  task automatic test_ignore_start();
    do_div(32'd100, 32'd7, 5, "start_in_run");
    do_div(32'd100, 32'd7, 32, "start_at_done_edge");
  endtask

  task automatic test_back_to_back();
    do_div(32'd100, 32'd7, 0, "b2b_first");
    do_div(32'd50, 32'd6, 0, "b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = a >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'h8000_0000);
      endcase
      do_div(a, b, 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || quotient !== 0 || remainder !== 0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h, required all 0", busy, done, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 0 || busy !== 0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_no_done: activity after abort, required busy=0 done=0");
    end
    prev_q = '0;
    prev_r = '0;
    do_div(32'd77, 32'd10, 0, "after_reset");
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
